// File: rtl/cim_tile_writeback.sv
// cim_tile_writeback: two-lane round-robin tile arbiter that packs
// 6x6 tiles into single SRAM words, one registered write per cycle.
module cim_tile_writeback #(
  parameter int DW = 12,
  parameter int TN = 6,
  parameter int MW = 512,
  parameter int AW = 8,
  parameter int CW = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [TN-1:0][TN-1:0][DW-1:0] pe1_tile_i,
  input  logic [7:0]                    pe1_od_i,
  input  logic [AW-1:0]                 pe1_addr_i,
  input  logic                          pe1_valid_i,
  output logic                          pe1_ready_o,
  input  logic [TN-1:0][TN-1:0][DW-1:0] pe2_tile_i,
  input  logic [7:0]                    pe2_od_i,
  input  logic [AW-1:0]                 pe2_addr_i,
  input  logic                          pe2_valid_i,
  output logic                          pe2_ready_o,
  input  logic                          halt_i,
  output logic                          mem_we_o,
  output logic [AW-1:0]                 mem_addr_o,
  output logic [7:0]                    mem_od_o,
  output logic [MW-1:0]                 mem_wdata_o,
  output logic [CW-1:0]                 wr_count_o,
  output logic                          busy_o
);

  typedef logic [TN-1:0][TN-1:0][DW-1:0] tile_t;

  typedef struct packed {
    tile_t         tile;
    logic [7:0]    od;
    logic [AW-1:0] addr;
  } slot_t;

  typedef enum logic {
    LANE1,
    LANE2
  } lane_e;

  slot_t         s1_q;
  slot_t         s2_q;
  slot_t         win;
  logic          full1_q;
  logic          full2_q;
  logic          gnt1;
  logic          gnt2;
  logic          gnt;
  logic          acc1;
  logic          acc2;
  lane_e         last_q;
  logic [MW-1:0] pack;

  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    if (!halt_i) begin
      unique case (1'b1)
        full1_q && full2_q: begin
          gnt1 = (last_q == LANE2);
          gnt2 = (last_q == LANE1);
        end
        full1_q && !full2_q: gnt1 = 1'b1;
        !full1_q && full2_q: gnt2 = 1'b1;
        default: ;
      endcase
    end
  end

  assign gnt = gnt1 | gnt2;

  // A granted lane frees its slot on the same edge it may be reloaded.
  assign pe1_ready_o = !full1_q || gnt1;
  assign pe2_ready_o = !full2_q || gnt2;
  assign acc1 = pe1_valid_i && pe1_ready_o;
  assign acc2 = pe2_valid_i && pe2_ready_o;

  always_comb begin
    win = s1_q;
    unique case (1'b1)
      gnt1:    win = s1_q;
      gnt2:    win = s2_q;
      default: win = s1_q;
    endcase
  end

  always_comb begin
    pack = '0;
    for (int r = 0; r < TN; r++) begin
      for (int c = 0; c < TN; c++) begin
        pack[DW*(TN*r+c) +: DW] = win.tile[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      full1_q <= 1'b0;
      full2_q <= 1'b0;
      last_q  <= LANE2;
    end else begin
      if (acc1) begin
        s1_q <= '{tile: pe1_tile_i, od: pe1_od_i, addr: pe1_addr_i};
      end
      if (acc2) begin
        s2_q <= '{tile: pe2_tile_i, od: pe2_od_i, addr: pe2_addr_i};
      end
      full1_q <= acc1 || (full1_q && !gnt1);
      full2_q <= acc2 || (full2_q && !gnt2);
      if (gnt) begin
        last_q <= gnt1 ? LANE1 : LANE2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_od_o    <= '0;
      mem_wdata_o <= '0;
      wr_count_o  <= '0;
    end else begin
      mem_we_o <= gnt;
      if (gnt) begin
        mem_addr_o  <= win.addr;
        mem_od_o    <= win.od;
        mem_wdata_o <= pack;
        wr_count_o  <= wr_count_o + CW'(1);
      end
    end
  end

  assign busy_o = full1_q || full2_q || mem_we_o;

endmodule
